// File: rtl/nfca_picc_pkg.sv
// nfca_picc_pkg: timing constants, FSM states and symbol encoding shared by the
// ISO14443A PICC transmitter and its Manchester modulator.
package nfca_picc_pkg;
   localparam logic [9:0] CLK_PER_BIT  = 10'd768;
   localparam logic [9:0] CLK_PER_HALF = 10'd384;
   localparam logic [6:0] SUBC_PERIOD  = 7'd96;
   localparam logic [6:0] SUBC_HIGH    = 7'd48;
   typedef enum logic [2:0] {ST_IDLE, ST_WAIT_FDT, ST_START, ST_DATA, ST_PARITY, ST_END} state_t;
   typedef enum logic [1:0] {SYM_ONE, SYM_ZERO, SYM_NONE} sym_t;
   function automatic sym_t bit_sym(input logic b);
      return b ? SYM_ONE : SYM_ZERO;
   endfunction
endpackage

// File: rtl/nfca_picc_manchester.sv
// nfca_picc_manchester: turns one symbol per 768-clk bit period into the
// subcarrier-modulated load drive; flags the final clk of every symbol.
module nfca_picc_manchester
   import nfca_picc_pkg::*;
(
   input  logic clk,
   input  logic rstn,
   input  logic sym_load_i,
   input  sym_t sym_i,
   output logic load_mod_o,
   output logic sym_last_o
);
   logic [9:0] pos_q, pos_d;
   logic [6:0] sc_q, sc_d;
   sym_t       sym_q, sym_d;
   logic       mod_half, load_mod_q, load_mod_d;
   assign sym_last_o = pos_q == CLK_PER_BIT - 10'd1;
   assign load_mod_o = load_mod_q;
   // Subcarrier phase restarts on every half-bit so each modulated half begins high
   always_comb begin
      pos_d      = (sym_load_i || sym_last_o) ? '0 : pos_q + 10'd1;
      sym_d      = sym_load_i ? sym_i : sym_q;
      sc_d       = (pos_d == '0 || pos_d == CLK_PER_HALF || sc_q == SUBC_PERIOD - 7'd1) ? '0 : sc_q + 7'd1;
      mod_half   = (sym_d == SYM_ONE) ? (pos_d < CLK_PER_HALF) : (sym_d == SYM_ZERO) && (pos_d >= CLK_PER_HALF);
      load_mod_d = mod_half && (sc_d < SUBC_HIGH);
   end
   always_ff @(posedge clk) begin
      if (!rstn) begin
         pos_q      <= '0;
         sc_q       <= '0;
         sym_q      <= SYM_NONE;
         load_mod_q <= 1'b0;
      end else begin
         pos_q      <= pos_d;
         sc_q       <= sc_d;
         sym_q      <= sym_d;
         load_mod_q <= load_mod_d;
      end
   end
endmodule

// File: rtl/nfca_picc_tx.sv
// nfca_picc_tx: PICC response transmitter; waits the frame delay after tx_trig,
// then frames bytes (S, LSB-first data, odd parity, E) onto the Manchester modulator.
module nfca_picc_tx
   import nfca_picc_pkg::*;
#(
   parameter int unsigned FDT_CLKS = 7032
)(
   input  logic       clk,
   input  logic       rstn,
   input  logic       tx_tvalid,
   output logic       tx_tready,
   input  logic [7:0] tx_tdata,
   input  logic       tx_tlast,
   input  logic [2:0] tx_tlastb,
   input  logic       tx_trig,
   output logic       load_mod,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       tx_underrun
);
   localparam logic [15:0] FDT_LOAD = 16'(FDT_CLKS - 1);
   state_t      state_q, state_d;
   logic [15:0] fdt_q, fdt_d;
   logic [7:0]  sh_q, sh_d;
   logic [2:0]  lastb_q, lastb_d, bi_q, bi_d, limit;
   logic        last_q, last_d, par_q, par_d, drop_q, drop_d;
   logic        expire, fetch, sym_load, sym_last;
   sym_t        sym;
   nfca_picc_manchester u_man (
      .clk        (clk),
      .rstn       (rstn),
      .sym_load_i (sym_load),
      .sym_i      (sym),
      .load_mod_o (load_mod),
      .sym_last_o (sym_last)
   );
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= ST_IDLE;
         fdt_q   <= '0;
         sh_q    <= '0;
         lastb_q <= '0;
         bi_q    <= '0;
         last_q  <= 1'b0;
         par_q   <= 1'b0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         fdt_q   <= fdt_d;
         sh_q    <= sh_d;
         lastb_q <= lastb_d;
         bi_q    <= bi_d;
         last_q  <= last_d;
         par_q   <= par_d;
         drop_q  <= drop_d;
      end
   end
   // par_q holds the XOR of data bits already handed to the modulator
   always_comb begin
      state_d = state_q;
      fdt_d   = fdt_q;
      sh_d    = sh_q;
      lastb_d = lastb_q;
      bi_d    = bi_q;
      last_d  = last_q;
      par_d   = par_q;
      drop_d  = 1'b0;
      case (state_q)
         ST_IDLE: if (tx_trig) begin
            state_d = ST_WAIT_FDT;
            fdt_d   = FDT_LOAD;
         end
         ST_WAIT_FDT: if (tx_trig) fdt_d = FDT_LOAD;
            else if (fdt_q != '0) fdt_d = fdt_q - 16'd1;
            else if (tx_tvalid) begin
               state_d = ST_START;
               sh_d    = tx_tdata;
               last_d  = tx_tlast;
               lastb_d = tx_tlastb;
            end else begin
               state_d = ST_IDLE;
               drop_d  = 1'b1;
            end
         ST_START: if (sym_last) begin
            state_d = ST_DATA;
            sh_d    = sh_q >> 1;
            par_d   = sh_q[0];
            bi_d    = '0;
         end
         ST_DATA: if (sym_last) begin
            if (bi_q == limit) state_d = (limit == 3'd7) ? ST_PARITY : ST_END;
            else begin
               sh_d  = sh_q >> 1;
               par_d = par_q ^ sh_q[0];
               bi_d  = bi_q + 3'd1;
            end
         end
         ST_PARITY: if (sym_last) begin
            if (fetch) begin
               state_d = ST_DATA;
               sh_d    = tx_tdata >> 1;
               par_d   = tx_tdata[0];
               last_d  = tx_tlast;
               lastb_d = tx_tlastb;
               bi_d    = '0;
            end else state_d = ST_END;
         end
         ST_END: if (sym_last) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end
   always_comb begin
      limit       = last_q ? lastb_q : 3'd7;
      expire      = state_q == ST_WAIT_FDT && !tx_trig && fdt_q == '0;
      fetch       = tx_tvalid && (expire || (state_q == ST_PARITY && sym_last && !last_q));
      tx_tready   = fetch;
      tx_underrun = !tx_tvalid && state_q == ST_PARITY && sym_last && !last_q;
      tx_done     = drop_q || (state_q == ST_END && sym_last);
      tx_busy     = drop_q || state_q != ST_IDLE;
      sym_load    = fetch || (sym_last && (state_q == ST_START || state_q == ST_DATA || state_q == ST_PARITY));
      sym         = state_q == ST_WAIT_FDT ? SYM_ONE :
                    state_q == ST_PARITY ? (fetch ? bit_sym(tx_tdata[0]) : SYM_NONE) :
                    (state_q == ST_DATA && bi_q == limit) ? (limit == 3'd7 ? bit_sym(!par_q) : SYM_NONE) :
                    bit_sym(sh_q[0]);
   end
endmodule

// File: tb/tb_nfca_picc_tx.sv
// tb_nfca_picc_tx: scenario tasks compare the DUT against a symbol-list model of
// the ISO14443A PICC frame (S, LSB-first data, odd parity, E, 848 kHz subcarrier).
module tb_nfca_picc_tx;
   localparam int FDT  = 1172;
   localparam int BITC = 768;
   localparam int MAXC = 24000;
   logic       clk = 1'b0, rstn = 1'b0, tx_tvalid = 1'b0, tx_tlast = 1'b0, tx_trig = 1'b0;
   logic [7:0] tx_tdata = '0;
   logic [2:0] tx_tlastb = '0;
   logic       tx_tready, load_mod, tx_busy, tx_done, tx_underrun;
   int         n_chk = 0, n_pass = 0;
   logic [7:0] fb [4];
   int         f_lastb;
   bit         lm_a [MAXC];
   int         first_mod, done_t, n_done, n_tready, end_t;
   bit         busy0, busy_after;
   int         tready_t [$], under_t [$];
   int         sq [$], exp_fetch [$];
   int         exp_start, exp_len, exp_done, exp_under;

   always #5 clk = ~clk;

   nfca_picc_tx #(.FDT_CLKS(FDT)) dut (
      .clk         (clk),
      .rstn        (rstn),
      .tx_tvalid   (tx_tvalid),
      .tx_tready   (tx_tready),
      .tx_tdata    (tx_tdata),
      .tx_tlast    (tx_tlast),
      .tx_tlastb   (tx_tlastb),
      .tx_trig     (tx_trig),
      .load_mod    (load_mod),
      .tx_busy     (tx_busy),
      .tx_done     (tx_done),
      .tx_underrun (tx_underrun)
   );

   // Symbol list of the frame: 1 = logic one / S, 0 = logic zero, 2 = E
   task automatic build_model(input int n, input int avail, input int retrig);
      sq.delete();
      exp_fetch.delete();
      exp_under = -1;
      exp_start = (retrig > 0 ? retrig : 0) + FDT;
      exp_len   = 0;
      exp_done  = exp_start;
      if (avail == 0) return;
      exp_fetch.push_back(exp_start - 1);
      sq.push_back(1);
      for (int i = 0; i < n; i++) begin
         int nb;
         nb = (i == n - 1) ? f_lastb + 1 : 8;
         for (int b = 0; b < nb; b++) sq.push_back(int'(fb[i][b]));
         if (nb == 8) begin
            sq.push_back(($countones(fb[i]) % 2 == 0) ? 1 : 0);
            if (i < n - 1) begin
               if (i + 1 < avail) exp_fetch.push_back(exp_start + sq.size() * BITC - 1);
               else begin
                  exp_under = exp_start + sq.size() * BITC - 1;
                  break;
               end
            end
         end
      end
      sq.push_back(2);
      exp_len  = sq.size();
      exp_done = exp_start + exp_len * BITC - 1;
   endtask

   function automatic bit exp_lm(input int t);
      int k, p;
      bit m;
      if (t < exp_start || t >= exp_start + exp_len * BITC) return 1'b0;
      k = (t - exp_start) / BITC;
      p = (t - exp_start) % BITC;
      if (sq[k] == 1) m = p < BITC / 2;
      else if (sq[k] == 0) m = p >= BITC / 2;
      else m = 1'b0;
      return m && ((p % (BITC / 2)) % 96) < 48;
   endfunction

   function automatic int wave_errs();
      int e;
      e = 0;
      for (int t = 0; t <= end_t; t++) if (lm_a[t] != exp_lm(t)) e++;
      return e;
   endfunction

   task automatic set_inputs(input int bi, input int n, input int avail);
      tx_tvalid = bi < n && bi < avail;
      tx_tdata  = fb[bi < 4 ? bi : 0];
      tx_tlast  = bi == n - 1;
      tx_tlastb = (bi == n - 1) ? 3'(f_lastb) : 3'($urandom);
   endtask

   // Trigger at edge 0, act as upstream source, record outputs per cycle
   task automatic capture(input int n, input int avail, input int retrig, input int budget);
      int bi;
      bit rdy;
      bi = 0;
      first_mod = -1; done_t = -1; n_done = 0; n_tready = 0; end_t = budget - 1;
      busy0 = 1'b0; busy_after = 1'b1;
      tready_t.delete();
      under_t.delete();
      @(posedge clk); #1;
      tx_trig = 1'b1;
      set_inputs(bi, n, avail);
      @(posedge clk); #1;
      tx_trig = retrig == 1;
      for (int t = 0; t < budget; t++) begin
         @(negedge clk);
         lm_a[t] = load_mod;
         if (load_mod && first_mod < 0) first_mod = t;
         if (t == 0) busy0 = tx_busy;
         if (tx_tready) begin n_tready++; tready_t.push_back(t); end
         if (tx_underrun) under_t.push_back(t);
         if (tx_done) begin n_done++; if (done_t < 0) done_t = t; end
         if (done_t >= 0 && t == done_t + 1) busy_after = tx_busy;
         rdy = tx_tready;
         @(posedge clk); #1;
         tx_trig = t + 2 == retrig;
         if (rdy) begin bi++; set_inputs(bi, n, avail); end
         if (done_t >= 0 && t >= done_t + 1) begin end_t = t; break; end
      end
      tx_trig = 1'b0;
      tx_tvalid = 1'b0;
   endtask

   task automatic test_reset();
      int bad;
      rstn = 1'b0; tx_trig = 1'b1; tx_tvalid = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_chk++; if (load_mod !== 1'b0) $display("FAIL reset_load_mod got %b want 0", load_mod); else n_pass++;
      n_chk++; if (tx_busy !== 1'b0) $display("FAIL reset_busy got %b want 0", tx_busy); else n_pass++;
      n_chk++; if ({tx_tready, tx_done, tx_underrun} !== 3'b000) $display("FAIL reset_pulses got %b want 000", {tx_tready, tx_done, tx_underrun}); else n_pass++;
      @(posedge clk); #1;
      rstn = 1'b1; tx_trig = 1'b0;
      bad = 0;
      repeat (50) begin
         @(negedge clk);
         if (tx_tready || tx_busy || load_mod) bad++;
      end
      n_chk++; if (bad !== 0) $display("FAIL idle_ignores_valid got %0d active cycles want 0", bad); else n_pass++;
      @(posedge clk); #1 tx_tvalid = 1'b0;
   endtask

   task automatic test_single();
      fb[0] = 8'h04; f_lastb = 7;
      build_model(1, 1, 0);
      capture(1, 1, 0, FDT + 12 * BITC + 50);
      n_chk++; if (first_mod !== FDT) $display("FAIL single_first_mod got %0d want %0d", first_mod, FDT); else n_pass++;
      n_chk++; if (done_t !== FDT + 11 * BITC - 1) $display("FAIL single_done got %0d want %0d", done_t, FDT + 11 * BITC - 1); else n_pass++;
      n_chk++; if (wave_errs() !== 0) $display("FAIL single_wave got %0d bad cycles want 0", wave_errs()); else n_pass++;
      n_chk++; if (n_tready !== 1) $display("FAIL single_tready_count got %0d want 1", n_tready); else n_pass++;
      n_chk++; if (n_tready > 0 && tready_t[0] !== FDT - 1) $display("FAIL single_tready_time got %0d want %0d", tready_t[0], FDT - 1); else n_pass++;
      n_chk++; if (busy0 !== 1'b1 || busy_after !== 1'b0) $display("FAIL single_busy got %b%b want 10", busy0, busy_after); else n_pass++;
      n_chk++; if (n_done !== 1 || under_t.size() !== 0) $display("FAIL single_pulses got done=%0d under=%0d want 1 0", n_done, under_t.size()); else n_pass++;
   endtask

   task automatic test_back_to_back();
      int rises, high;
      fb[0] = 8'h44; fb[1] = 8'h00; f_lastb = 7;
      build_model(2, 2, 0);
      capture(2, 2, 0, FDT + 21 * BITC + 50);
      n_chk++; if (done_t !== FDT + 20 * BITC - 1) $display("FAIL b2b_done got %0d want %0d", done_t, FDT + 20 * BITC - 1); else n_pass++;
      n_chk++; if (n_tready !== 2) $display("FAIL b2b_tready_count got %0d want 2", n_tready); else n_pass++;
      n_chk++; if (n_tready > 1 && tready_t[1] !== FDT + 10 * BITC - 1) $display("FAIL b2b_tready2 got %0d want %0d", tready_t[1], FDT + 10 * BITC - 1); else n_pass++;
      n_chk++; if (wave_errs() !== 0) $display("FAIL b2b_wave got %0d bad cycles want 0", wave_errs()); else n_pass++;
      n_chk++; if (lm_a[FDT + 10 * BITC - 100] !== 1'b0 || lm_a[FDT + 9 * BITC + 10] !== 1'b1) $display("FAIL b2b_parity1 got %b%b want 10", lm_a[FDT + 9 * BITC + 10], lm_a[FDT + 10 * BITC - 100]); else n_pass++;
      rises = 0; high = 0;
      for (int t = FDT; t < FDT + BITC / 2; t++) begin
         if (lm_a[t] && !lm_a[t - 1]) rises++;
         if (lm_a[t]) high++;
      end
      n_chk++; if (rises !== 4 || high !== 192) $display("FAIL b2b_subcarrier got %0d rises %0d high want 4 192", rises, high); else n_pass++;
   endtask

   task automatic test_partial();
      fb[0] = 8'h13; f_lastb = 4;
      build_model(1, 1, 0);
      capture(1, 1, 0, FDT + 8 * BITC + 50);
      n_chk++; if (done_t !== FDT + 7 * BITC - 1) $display("FAIL partial_done got %0d want %0d", done_t, FDT + 7 * BITC - 1); else n_pass++;
      n_chk++; if (wave_errs() !== 0) $display("FAIL partial_wave got %0d bad cycles want 0", wave_errs()); else n_pass++;
      n_chk++; if (n_tready !== 1) $display("FAIL partial_tready got %0d want 1", n_tready); else n_pass++;
   endtask

   task automatic test_underrun();
      int late;
      fb[0] = 8'($urandom); fb[1] = 8'($urandom); f_lastb = 7;
      build_model(2, 1, 0);
      capture(2, 1, 0, FDT + 13 * BITC + 50);
      n_chk++; if (under_t.size() !== 1) $display("FAIL underrun_count got %0d want 1", under_t.size()); else n_pass++;
      n_chk++; if (under_t.size() > 0 && under_t[0] !== FDT + 10 * BITC - 1) $display("FAIL underrun_time got %0d want %0d", under_t[0], FDT + 10 * BITC - 1); else n_pass++;
      n_chk++; if (done_t !== FDT + 11 * BITC - 1) $display("FAIL underrun_done got %0d want %0d", done_t, FDT + 11 * BITC - 1); else n_pass++;
      late = 0;
      for (int t = FDT + 10 * BITC; t <= end_t; t++) if (lm_a[t]) late++;
      n_chk++; if (late !== 0) $display("FAIL underrun_quiet got %0d modulated cycles want 0", late); else n_pass++;
      n_chk++; if (wave_errs() !== 0 || n_tready !== 1) $display("FAIL underrun_wave got %0d bad %0d tready want 0 1", wave_errs(), n_tready); else n_pass++;
   endtask

   task automatic test_drop();
      fb[0] = 8'($urandom); f_lastb = 7;
      capture(1, 0, 0, FDT + 100);
      n_chk++; if (done_t !== FDT) $display("FAIL drop_done got %0d want %0d", done_t, FDT); else n_pass++;
      n_chk++; if (first_mod !== -1 || n_tready !== 0 || under_t.size() !== 0) $display("FAIL drop_quiet got mod=%0d tready=%0d under=%0d want -1 0 0", first_mod, n_tready, under_t.size()); else n_pass++;
      capture(1, 0, 500, FDT + 700);
      n_chk++; if (done_t !== 500 + FDT) $display("FAIL retrig_done got %0d want %0d", done_t, 500 + FDT); else n_pass++;
      n_chk++; if (first_mod !== -1 || n_done !== 1) $display("FAIL retrig_quiet got mod=%0d done=%0d want -1 1", first_mod, n_done); else n_pass++;
   endtask

   task automatic test_reset_mid();
      int bad;
      @(posedge clk); #1;
      tx_trig = 1'b1; tx_tvalid = 1'b1; tx_tdata = 8'($urandom); tx_tlast = 1'b1; tx_tlastb = 3'd7;
      @(posedge clk); #1;
      tx_trig = 1'b0;
      repeat (FDT + 3 * BITC + 99) @(posedge clk);
      @(negedge clk);
      n_chk++; if (tx_busy !== 1'b1) $display("FAIL mid_busy got %b want 1", tx_busy); else n_pass++;
      @(posedge clk); #1 rstn = 1'b0;
      @(posedge clk); #1 rstn = 1'b1;
      @(negedge clk);
      n_chk++; if ({load_mod, tx_busy, tx_tready, tx_done, tx_underrun} !== 5'b0) $display("FAIL mid_reset got %b want 00000", {load_mod, tx_busy, tx_tready, tx_done, tx_underrun}); else n_pass++;
      bad = 0;
      repeat (2000) begin
         @(negedge clk);
         if (load_mod || tx_busy || tx_tready || tx_done) bad++;
      end
      n_chk++; if (bad !== 0) $display("FAIL mid_after_reset got %0d active cycles want 0", bad); else n_pass++;
      @(posedge clk); #1 tx_tvalid = 1'b0;
   endtask

   task automatic test_random();
      int n;
      for (int r = 0; r < 2; r++) begin
         n = (r == 0) ? 2 : 1;
         for (int i = 0; i < 4; i++) fb[i] = 8'($urandom);
         f_lastb = $urandom_range(0, 7);
         build_model(n, n, 0);
         capture(n, n, 0, FDT + (9 * n + 3) * BITC + 50);
         n_chk++; if (done_t !== exp_done) $display("FAIL rand%0d_done got %0d want %0d", r, done_t, exp_done); else n_pass++;
         n_chk++; if (wave_errs() !== 0) $display("FAIL rand%0d_wave got %0d bad cycles want 0", r, wave_errs()); else n_pass++;
         n_chk++; if (n_tready !== exp_fetch.size()) $display("FAIL rand%0d_tready_count got %0d want %0d", r, n_tready, exp_fetch.size()); else n_pass++;
         for (int i = 0; i < n_tready && i < exp_fetch.size(); i++) begin
            n_chk++; if (tready_t[i] !== exp_fetch[i]) $display("FAIL rand%0d_tready%0d got %0d want %0d", r, i, tready_t[i], exp_fetch[i]); else n_pass++;
         end
         n_chk++; if (under_t.size() !== 0 || busy_after !== 1'b0) $display("FAIL rand%0d_end got under=%0d busy=%b want 0 0", r, under_t.size(), busy_after); else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_partial();
      test_underrun();
      test_drop();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/nfca_picc_tx.md
Name: nfca_picc_tx

Overview:
- PICC-side (card-emulation) transmitter for ISO14443A, i.e. the card end of the link our reader controller talks to.
- Takes a byte stream, frames it (S, LSB-first data, odd parity, E) and Manchester-encodes it onto an 847.5 kHz subcarrier as a load-modulation drive signal.
- Transmission starts a fixed frame-delay time after the end of the reader command.
- Sits beside a future PICC receiver, which supplies tx_trig.

Parameters:
- FDT_CLKS, 7032, clk cycles from the tx_trig sample to the first S modulation (1172 carrier cycles x 6); legal range 2..65535.

Ports:
- clk  input  1  81.36 MHz clock (6 x 13.56 MHz)
- rstn  input  1  synchronous active-low reset: 0 = reset, 1 = work
- tx_tvalid  input  1  response byte valid
- tx_tready  output  1  one-cycle pulse: byte accepted this cycle
- tx_tdata  input  8  response byte, sent LSB first
- tx_tlast  input  1  last byte of the frame
- tx_tlastb  input  3  valid bits in the last byte: 0 = 1 bit ... 7 = 8 bits
- tx_trig  input  1  pulse marking the end of the reader frame (last pause end)
- load_mod  output  1  registered; 1 = switch load (modulate)
- tx_busy  output  1  high from tx_trig acceptance until the frame ends or is dropped
- tx_done  output  1  one-cycle pulse at the end of E, or at a dropped frame
- tx_underrun  output  1  one-cycle pulse when a frame is aborted for lack of data

Behaviour:
- Reset (rstn=0 sampled on clk): state IDLE, all counters 0. load_mod, tx_tready, tx_busy, tx_done, tx_underrun all 0 from the next edge. Applies mid-frame too; no E is sent.
- Timing:
  - Bit period 768 clk; half-bit 384 clk.
  - Subcarrier period 96 clk: 48 clk high, 48 clk low, 4 periods per half-bit.
  - Subcarrier phase restarts at each modulated half-bit, so every modulated half starts with load_mod=1.
- Symbol coding:
  - Logic 1 and S: first half modulated, second half load_mod=0.
  - Logic 0: first half 0, second half modulated.
  - E: a full bit period of 0.
- States: IDLE, WAIT_FDT, START, DATA, PARITY, END.
- IDLE:
  - tx_trig=1 -> WAIT_FDT, counter loaded, tx_busy=1.
  - tx_tvalid is ignored in IDLE; no byte is accepted.
- WAIT_FDT:
  - Counts FDT_CLKS cycles. A tx_trig=1 inside this state restarts the count.
  - At expiry with tx_tvalid=1: tx_tready=1 that cycle, byte/tlast/tlastb latched, -> START.
  - At expiry with tx_tvalid=0: drop the frame, tx_done pulse, tx_underrun stays 0, -> IDLE; load_mod never rises.
- START: load_mod first rises in the cycle FDT_CLKS clocks after the cycle tx_trig was sampled. One S symbol, then -> DATA.
- DATA:
  - Sends 8 bits, or tlastb+1 bits for a tlast byte, LSB first; running parity is accumulated.
  - After 8 bits -> PARITY.
  - After a partial last byte (tlastb<7) -> END with no parity bit.
- PARITY:
  - Sends the odd-parity bit (data ones + P is odd).
  - In the final clk of the parity bit:
    - If the latched byte was tlast -> END.
    - Else if tx_tvalid=1 -> tx_tready pulse, latch, -> DATA.
    - Else tx_underrun pulse, -> END (frame aborted with E).
- END: one E period. In its final clk tx_done=1, tx_busy drops next cycle, -> IDLE.
- tx_trig while in START/DATA/PARITY/END is ignored.
- Bytes offered while busy are not taken except at the defined fetch points. Upstream discards the rest of an aborted frame.
- tx_tlastb is ignored when tx_tlast=0.
- Frame length for N full bytes: 2+9N bit periods.

Decomposition:
- Package nfca_picc_pkg holds:
  - constants CLK_PER_BIT=768, CLK_PER_HALF=384, SUBC_PERIOD=96, SUBC_HIGH=48;
  - enum typedef of the six states;
  - 2-bit symbol typedef {SYM_ONE, SYM_ZERO, SYM_NONE}.
- Sub-module nfca_picc_manchester:
  - takes a symbol plus a sym_load strobe;
  - owns the 768-clk bit timer and the subcarrier counter;
  - drives load_mod;
  - issues sym_last in the final clk of each symbol.
- The top holds the framing FSM, FDT counter, parity and handshake.

Test Plan:
- FDT_CLKS=7032, one byte 0x04 with tlast, tlastb=7, trig at cycle 0:
  - first load_mod=1 at cycle 7032;
  - bit sequence S,0,0,1,0,0,0,0,0,P=0,E;
  - tx_done at cycle 7032+11*768-1;
  - exactly one tx_tready.
- Two bytes 0x44 then 0x00:
  - parity bits 1 and 1; 20 bit periods total;
  - second tx_tready in the last clk of the first parity bit;
  - each modulated half shows 4 x (48 high / 48 low).
- Single byte tlastb=4 (5 bits), data 0x13:
  - S,1,1,0,0,1,E with no parity;
  - frame 7 bit periods.
- Two-byte frame, tx_tvalid dropped before byte 2:
  - tx_underrun pulse in the last clk of parity 1, then E, then tx_done;
  - load_mod stays 0 after parity.
- tx_trig with tx_tvalid=0 at expiry: tx_done at cycle 7032, load_mod stays 0, no tready. A second trig at cycle 3000 of WAIT_FDT moves expiry to 3000+7032.
- rstn=0 mid-DATA: all outputs 0 on the next edge, state IDLE. A new trig afterwards produces a correct frame.
